// File: rtl/dsp_bus_regfile_pkg.sv
// Shared constants and address decode for the DSP bus register file.
package dsp_bus_pkg;

    localparam int unsigned STAT_OFS_STATUS = 0;
    localparam int unsigned STAT_OFS_LEVEL  = 1;
    localparam int unsigned STAT_OFS_STICKY = 2;
    localparam int unsigned STAT_OFS_MASK   = 3;
    localparam int unsigned STAT_OFS_ID     = 4;

    localparam logic [15:0] ID_CONST = 16'hC0D1;

    localparam int unsigned DEF_OUT_BASE  = 'h0010;
    localparam int unsigned DEF_STAT_BASE = 'h0020;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_STATUS,
        SEL_LEVEL,
        SEL_STICKY,
        SEL_MASK,
        SEL_ID
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] idx;
    } reg_dec_t;

    // Shared by the write-commit path (captured address) and the read mux (live address).
    function automatic reg_dec_t decode(input logic [31:0] addr, input int unsigned out_base,
                                        input int unsigned stat_base, input int unsigned n_out);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.idx = '0;
        if (addr >= out_base && addr < out_base + n_out) begin
            d.sel = SEL_OUT;
            d.idx = 4'(addr - out_base);
        end else if (addr >= stat_base && addr <= stat_base + STAT_OFS_ID) begin
            case (addr - stat_base)
                STAT_OFS_STATUS: d.sel = SEL_STATUS;
                STAT_OFS_LEVEL:  d.sel = SEL_LEVEL;
                STAT_OFS_STICKY: d.sel = SEL_STICKY;
                STAT_OFS_MASK:   d.sel = SEL_MASK;
                STAT_OFS_ID:     d.sel = SEL_ID;
                default:         d.sel = SEL_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/dsp_bus_regfile_if.sv
// DSP asynchronous external-memory bus: strobes, address, split data in/out and pin enable.
interface dsp_bus_regfile_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_IN;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_OE;
    logic              CSn;
    logic              WEn;
    logic              OEn;

    modport master (
        output ADDR, DATA_IN, CSn, WEn, OEn,
        input  DATA_OUT, DATA_OE
    );

    modport slave (
        input  ADDR, DATA_IN, CSn, WEn, OEn,
        output DATA_OUT, DATA_OE
    );
endinterface

// File: rtl/dsp_bus_regfile_fault_filter.sv
// Per-bit fault qualifier: asserts after FILT_CYCLES consecutive active cycles, drops at once.
// Compiled only when DSP_BUS_FAULT_FILTER_EN is defined.
`ifdef DSP_BUS_FAULT_FILTER_EN
module fault_filter #(
    parameter int unsigned FILT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic act_i,
    output logic level_o
);
    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts earlier active cycles, so the current one completes the run.
    always_comb begin
        cnt_d = cnt_q;
        if (!act_i)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign level_o = act_i && (cnt_q == CNT_MAX);
endmodule
`endif

// File: rtl/dsp_bus_regfile.sv
// Register file behind the DSP async bus: N output regs, status window, maskable sticky faults.
// Optional fault qualification filter: define DSP_BUS_FAULT_FILTER_EN.
module dsp_bus_regfile
    import dsp_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned N_OUT       = 8,
    parameter int unsigned OUT_BASE    = DEF_OUT_BASE,
    parameter int unsigned STAT_BASE   = DEF_STAT_BASE,
    parameter int unsigned FAULT_W     = 8,
    parameter int unsigned FILT_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    dsp_bus_regfile_if.slave        bus,
    input  logic [DATA_W-1:0]       STATUS_IN,
    input  logic [FAULT_W-1:0]      FAULT_IN,
    output logic [N_OUT*DATA_W-1:0] OUT_REGS,
    output logic                    FAULT_XINT
);

    if (N_OUT < 1 || N_OUT > 16 || FAULT_W < 1 || FAULT_W > DATA_W || FILT_CYCLES < 1) begin : g_bad_cfg
        $error("dsp_bus_regfile: parameter out of range");
    end

    logic [1:0]         cs_sync_q, we_sync_q;
    logic               we_dly_q;
    logic [FAULT_W-1:0] flt_meta_q, flt_s_q;
    logic [FAULT_W-1:0] level;

    logic [ADDR_W-1:0]              cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]              cap_data_q, cap_data_d;
    logic                           wr_pend_q, wr_pend_d;
    logic [N_OUT-1:0][DATA_W-1:0]   out_q, out_d;
    logic [FAULT_W-1:0]             sticky_q, sticky_d;
    logic [FAULT_W-1:0]             mask_q, mask_d;
    logic [FAULT_W-1:0]             w1c;
    logic                           xint_q, xint_d;
    logic [DATA_W-1:0]              rd_q, rd_d;
    logic                           we_rise, commit;
    reg_dec_t                       wdec, rdec;

    // Synchronizers idle high so reset looks like a deselected bus with no faults.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cs_sync_q  <= '1;
            we_sync_q  <= '1;
            we_dly_q   <= 1'b1;
            flt_meta_q <= '1;
            flt_s_q    <= '1;
        end else begin
            cs_sync_q  <= {cs_sync_q[0], bus.CSn};
            we_sync_q  <= {we_sync_q[0], bus.WEn};
            we_dly_q   <= we_sync_q[1];
            flt_meta_q <= FAULT_IN;
            flt_s_q    <= flt_meta_q;
        end
    end

`ifdef DSP_BUS_FAULT_FILTER_EN
    for (genvar b = 0; b < FAULT_W; b++) begin : g_filt
        fault_filter #(
            .FILT_CYCLES(FILT_CYCLES)
        ) u_filt (
            .clk_i  (CLK),
            .rst_i  (RESET),
            .act_i  (~flt_s_q[b]),
            .level_o(level[b])
        );
    end
`else
    assign level = ~flt_s_q;
`endif

    // Capture repeats every strobed cycle; the last sample before WEn rises is what commits.
    always_comb begin
        we_rise    = we_sync_q[1] & ~we_dly_q;
        commit     = we_rise & wr_pend_q;
        wdec       = decode(32'(cap_addr_q), OUT_BASE, STAT_BASE, N_OUT);
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        wr_pend_d  = wr_pend_q;
        out_d      = out_q;
        mask_d     = mask_q;
        w1c        = '0;

        if (!cs_sync_q[1] && !we_sync_q[1]) begin
            cap_addr_d = bus.ADDR;
            cap_data_d = bus.DATA_IN;
            wr_pend_d  = 1'b1;
        end else if (commit) begin
            wr_pend_d = 1'b0;
        end

        if (commit) begin
            case (wdec.sel)
                SEL_OUT: begin
                    for (int i = 0; i < N_OUT; i++)
                        if (wdec.idx == 4'(i))
                            out_d[i] = cap_data_q;
                end
                SEL_STICKY: w1c    = cap_data_q[FAULT_W-1:0];
                SEL_MASK:   mask_d = cap_data_q[FAULT_W-1:0];
                default: ;
            endcase
        end

        // A live fault re-sets its bit even while it is being cleared.
        sticky_d = (sticky_q & ~w1c) | level;
        xint_d   = ~|(sticky_q & mask_q);
    end

    always_comb begin
        rdec = decode(32'(bus.ADDR), OUT_BASE, STAT_BASE, N_OUT);
        rd_d = '0;
        if (!bus.CSn && !bus.OEn) begin
            case (rdec.sel)
                SEL_OUT: begin
                    for (int i = 0; i < N_OUT; i++)
                        if (rdec.idx == 4'(i))
                            rd_d = out_q[i];
                end
                SEL_STATUS: rd_d = STATUS_IN;
                SEL_LEVEL:  rd_d = DATA_W'(level);
                SEL_STICKY: rd_d = DATA_W'(sticky_q);
                SEL_MASK:   rd_d = DATA_W'(mask_q);
                SEL_ID:     rd_d = DATA_W'(ID_CONST);
                default:    rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_addr_q <= '0;
            cap_data_q <= '0;
            wr_pend_q  <= 1'b0;
            out_q      <= '0;
            sticky_q   <= '0;
            mask_q     <= '1;
            xint_q     <= 1'b1;
            rd_q       <= '0;
        end else begin
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            wr_pend_q  <= wr_pend_d;
            out_q      <= out_d;
            sticky_q   <= sticky_d;
            mask_q     <= mask_d;
            xint_q     <= xint_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.DATA_OE  = ~bus.CSn & ~bus.OEn;
    assign bus.DATA_OUT = rd_q;
    assign OUT_REGS     = out_q;
    assign FAULT_XINT   = xint_q;

endmodule
